wall_slice_renderer: RTL and testbench

WALL_SLICE_RENDERER -- requirements
Module: wall_slice_renderer

---
 rtl/wall_slice_renderer.sv | 178 +++++++++++++++++
 tb/tb_wall_slice_renderer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wall_slice_renderer.sv
// Wall slice renderer: once per line, divides a fixed wall constant by the
// traced visual distance to obtain the wall half-height, then paints each
// pixel of the next line as ceiling, wall or floor around a centre column.
//
// Optional feature macro: WALL_SIDE_SHADE_EN (shade Y-side walls with
// WALL1_COLOR; when undefined every wall uses WALL0_COLOR).
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-high reset
//   hmax       - end-of-line strobe (one clock)
//   i_side     - wall side of the traced ray, sampled on hmax
//   i_vdist    - UQ7.9 visual distance, sampled on hmax
//   i_hpos     - current horizontal pixel position
//   i_visible  - active display flag
//   o_rgb      - registered {R,G,B} 2-bit-per-channel pixel colour
//   o_busy     - division in progress
//   o_height   - half-height currently on display
module wall_slice_renderer #(
  parameter int unsigned HALF_K      = 256,
  parameter int unsigned H_CENTER    = 320,
  parameter logic [5:0]  CEIL_COLOR  = 6'b000001,
  parameter logic [5:0]  FLOOR_COLOR = 6'b010101,
  parameter logic [5:0]  WALL0_COLOR = 6'b110000,
  parameter logic [5:0]  WALL1_COLOR = 6'b100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hmax,
  input  logic        i_side,
  input  logic [15:0] i_vdist,
  input  logic [9:0]  i_hpos,
  input  logic        i_visible,
  output logic [5:0]  o_rgb,
  output logic        o_busy,
  output logic [9:0]  o_height
);

  localparam logic [17:0] Dividend = 18'(HALF_K << 9);
  localparam logic [4:0]  LastStep = 5'd17;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] vdist_q, vdist_d;
  logic [15:0] rem_q, rem_d;
  logic [17:0] quo_q, quo_d;       // dividend shifts out MSB first, quotient shifts in
  logic [4:0]  cnt_q, cnt_d;
  logic [9:0]  stage_h_q, stage_h_d;
  logic [9:0]  height_q, height_d;
  logic [5:0]  rgb_q, rgb_d;

  logic [16:0] shifted;
  logic [16:0] diff;
  logic [5:0]  wall_color;

`ifdef WALL_SIDE_SHADE_EN
  logic side_q, side_d;
  logic stage_side_q, stage_side_d;
  logic disp_side_q, disp_side_d;
  assign wall_color = disp_side_q ? WALL1_COLOR : WALL0_COLOR;
`else
  logic unused_side;
  assign unused_side = i_side;
  assign wall_color  = WALL0_COLOR;
`endif

  assign shifted = {rem_q, quo_q[17]};
  assign diff    = shifted - {1'b0, vdist_q};

  always_comb begin
    state_d   = state_q;
    vdist_d   = vdist_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    stage_h_d = stage_h_q;
    height_d  = height_q;
`ifdef WALL_SIDE_SHADE_EN
    side_d       = side_q;
    stage_side_d = stage_side_q;
    disp_side_d  = disp_side_q;
`endif

    unique case (state_q)
      StIdle: ;
      StDiv: begin
        if (shifted >= {1'b0, vdist_q}) begin
          rem_d = diff[15:0];
          quo_d = {quo_q[16:0], 1'b1};
        end else begin
          rem_d = shifted[15:0];
          quo_d = {quo_q[16:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastStep) state_d = StDone;
      end
      StDone: begin
        // Zero distance or a too-close wall saturates to the full screen.
        if (vdist_q == 16'd0 || quo_q > 18'(H_CENTER)) stage_h_d = 10'(H_CENTER);
        else                                          stage_h_d = quo_q[9:0];
`ifdef WALL_SIDE_SHADE_EN
        stage_side_d = side_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new line always wins: present the last finished result and restart,
    // abandoning any division still in flight.
    if (hmax) begin
      vdist_d  = i_vdist;
      height_d = stage_h_q;
      rem_d    = 16'd0;
      quo_d    = Dividend;
      cnt_d    = 5'd0;
      state_d  = StDiv;
`ifdef WALL_SIDE_SHADE_EN
      side_d      = i_side;
      disp_side_d = stage_side_q;
`endif
    end
  end

  // Span compare in 11-bit signed so a full-height wall reaches column 0
  // and 2*H_CENTER-1 without wrapping.
  logic signed [10:0] hpos_s, left_s, right_s;
  assign hpos_s  = $signed({1'b0, i_hpos});
  assign left_s  = $signed(11'(H_CENTER) - {1'b0, height_q});
  assign right_s = $signed(11'(H_CENTER) + {1'b0, height_q});

  always_comb begin
    rgb_d = 6'd0;
    if (i_visible) begin
      if (hpos_s < left_s)       rgb_d = CEIL_COLOR;
      else if (hpos_s < right_s) rgb_d = wall_color;
      else                       rgb_d = FLOOR_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      vdist_q   <= 16'd0;
      rem_q     <= 16'd0;
      quo_q     <= 18'd0;
      cnt_q     <= 5'd0;
      stage_h_q <= 10'd0;
      height_q  <= 10'd0;
      rgb_q     <= 6'd0;
`ifdef WALL_SIDE_SHADE_EN
      side_q       <= 1'b0;
      stage_side_q <= 1'b0;
      disp_side_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vdist_q   <= vdist_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      stage_h_q <= stage_h_d;
      height_q  <= height_d;
      rgb_q     <= rgb_d;
`ifdef WALL_SIDE_SHADE_EN
      side_q       <= side_d;
      stage_side_q <= stage_side_d;
      disp_side_q  <= disp_side_d;
`endif
    end
  end

  assign o_rgb    = rgb_q;
  assign o_busy   = (state_q == StDiv);
  assign o_height = height_q;

endmodule

// File: tb/tb_wall_slice_renderer.sv
module tb_wall_slice_renderer;

  localparam int HalfK  = 256;
  localparam int Center = 320;
  localparam int Ceil   = 6'b000001;
  localparam int Floor  = 6'b010101;
  localparam int Wall0  = 6'b110000;
  localparam int Wall1  = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hmax = 1'b0;
  logic        i_side = 1'b0;
  logic [15:0] i_vdist = 16'd0;
  logic [9:0]  i_hpos = 10'd0;
  logic        i_visible = 1'b0;
  logic [5:0]  o_rgb;
  logic        o_busy;
  logic [9:0]  o_height;

  wall_slice_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .hmax      (hmax),
    .i_side    (i_side),
    .i_vdist   (i_vdist),
    .i_hpos    (i_hpos),
    .i_visible (i_visible),
    .o_rgb     (o_rgb),
    .o_busy    (o_busy),
    .o_height  (o_height)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side model of the staging and display registers.
  int stage_h = 0, stage_s = 0, disp_h = 0, disp_s = 0;
  int pend_h = 0, pend_s = 0;

  int exp_q[$];
  string tag_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int calc_height(input int vdist);
    int q;
    if (vdist == 0) return Center;
    q = (HalfK * 512) / vdist;
    return (q > Center) ? Center : q;
  endfunction

  function automatic int calc_rgb(input int h, input int vis, input int ht, input int side);
    int wall;
`ifdef WALL_SIDE_SHADE_EN
    wall = side ? Wall1 : Wall0;
`else
    wall = Wall0;
`endif
    if (!vis) return 0;
    if (h < Center - ht) return Ceil;
    if (h < Center + ht) return wall;
    return Floor;
  endfunction

  // Strobe hmax for one clock; returns at the following falling edge.
  task automatic pulse_hmax(input int vdist, input int side);
    @(negedge clk);
    hmax = 1'b1;
    i_vdist = 16'(vdist);
    i_side = side[0];
    @(negedge clk);
    hmax = 1'b0;
    disp_h = stage_h;
    disp_s = stage_s;
    pend_h = calc_height(vdist);
    pend_s = side;
    check_eq($sformatf("height_after_hmax v=%0d", vdist), int'(o_height), disp_h);
  endtask

  // Count busy cycles (bounded), then let DONE commit the staging value.
  task automatic finish_div(input string tag);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!o_busy) break;
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, n, 18);
    @(negedge clk);
    @(negedge clk);
    stage_h = pend_h;
    stage_s = pend_s;
  endtask

  task automatic line(input int vdist, input int side);
    pulse_hmax(vdist, side);
    finish_div($sformatf("line v=%0d", vdist));
  endtask

  // Scoreboard sweep: expected pixel pushed when driven, popped one clock later.
  task automatic sweep(input int lo, input int hi, input int vis);
    for (int h = lo; h <= hi; h++) begin
      @(negedge clk);
      if (exp_q.size() > 0) check_eq(tag_q.pop_front(), int'(o_rgb), exp_q.pop_front());
      i_hpos = 10'(h);
      i_visible = vis[0];
      exp_q.push_back(calc_rgb(h, vis, disp_h, disp_s));
      tag_q.push_back($sformatf("rgb h=%0d ht=%0d vis=%0d", h, disp_h, vis));
    end
    @(negedge clk);
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), int'(o_rgb), exp_q.pop_front());
    i_visible = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_busy", int'(o_busy), 0);
    check_eq("reset_height", int'(o_height), 0);
    check_eq("reset_rgb", int'(o_rgb), 0);
    reset = 1'b0;

    // First line shows the reset staging: pure ceiling/floor.
    line(512, 0);
    sweep(310, 330, 1);
    line(1024, 1);                 // displays 256 from vdist 512
    sweep(0, 639, 1);
    line(16'hFFFF, 0);             // displays 128, side 1
    sweep(180, 460, 1);
    line(256, 0);                  // displays 2
    sweep(310, 330, 1);
    line(0, 0);                    // displays 320 (saturated from 256)
    sweep(0, 639, 1);
    line(512, 0);                  // displays 320 (vdist 0)
    sweep(0, 639, 1);
    check_eq("height_sat_zero", int'(o_height), 320);

    // Abort: restart 5 clocks into a division.
    pulse_hmax(1024, 1);
    repeat (4) @(negedge clk);
    check_eq("busy_mid_div", int'(o_busy), 1);
    pulse_hmax(16'hFFFF, 0);       // display still the prior staging (256)
    finish_div("abort");
    pulse_hmax(512, 0);            // now shows 2, never the aborted 128
    finish_div("after_abort");
    sweep(315, 325, 1);

    // Reset mid-division with a simultaneous hmax.
    pulse_hmax(1024, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hmax = 1'b1;
    i_vdist = 16'd512;
    @(negedge clk);
    hmax = 1'b0;
    check_eq("rst_mid_busy", int'(o_busy), 0);
    check_eq("rst_mid_height", int'(o_height), 0);
    @(negedge clk);
    reset = 1'b0;
    stage_h = 0; stage_s = 0; disp_h = 0; disp_s = 0;
    sweep(0, 20, 0);
    check_eq("rst_idle_busy", int'(o_busy), 0);
    line(512, 0);                  // staging was cleared: still height 0
    sweep(318, 322, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
